// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note codes, half-period table and tone FSM states
package piano_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;
    localparam logic [3:0] NOTE_D5   = 4'd9;
    localparam logic [3:0] NOTE_E5   = 4'd10;
    localparam logic [3:0] NOTE_F5   = 4'd11;
    localparam logic [3:0] NOTE_G5   = 4'd12;
    localparam logic [3:0] NOTE_A5   = 4'd13;
    localparam logic [3:0] NOTE_B5   = 4'd14;
    localparam logic [3:0] NOTE_RSVD = 4'd15;

    localparam int HALF_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_TONE = 2'd2
    } tone_state_t;

    // Half-period in 100 MHz clocks for each sounding note; rest/reserved give 0.
    function automatic logic [HALF_W-1:0] note_half(input logic [3:0] note);
        logic [HALF_W-1:0] h;
        case (note)
            NOTE_C4: h = 18'd191110;
            NOTE_D4: h = 18'd170265;
            NOTE_E4: h = 18'd151685;
            NOTE_F4: h = 18'd143172;
            NOTE_G4: h = 18'd127551;
            NOTE_A4: h = 18'd113636;
            NOTE_B4: h = 18'd101239;
            NOTE_C5: h = 18'd95555;
            NOTE_D5: h = 18'd85132;
            NOTE_E5: h = 18'd75843;
            NOTE_F5: h = 18'd71586;
            NOTE_G5: h = 18'd63776;
            NOTE_A5: h = 18'd56818;
            NOTE_B5: h = 18'd50620;
            default: h = '0;
        endcase
        return h;
    endfunction

    function automatic logic note_valid(input logic [3:0] note);
        return (note >= NOTE_C4) && (note <= NOTE_B5);
    endfunction

endpackage

// File: rtl/piano_tone_gen_rom.sv
// rtl/piano_tone_gen_rom.sv - combinational note to half-period lookup
// Ports:
//   i_note  4-bit note code
//   o_half  half-period in clocks after HALF_SHIFT is applied (0 for rest/reserved)
module note_period_rom
    import piano_pkg::*;
#(
    parameter int HALF_SHIFT = 0
) (
    input  logic [3:0]        i_note,
    output logic [HALF_W-1:0] o_half
);

    assign o_half = note_half(i_note) >> HALF_SHIFT;

endmodule

// File: rtl/piano_tone_gen.sv
// rtl/piano_tone_gen.sv - note code to buzzer square wave with articulation gap
// Ports:
//   i_clk          system clock (100 MHz)
//   i_rst_n        asynchronous active-low reset
//   i_en           1 = sound allowed, 0 = mute and return to idle
//   i_note_in      0 rest, 1..14 C4..B5, 15 reserved (rest)
//   o_buzzer_out   square wave to the buzzer pin
//   o_playing      1 while a tone is sounding
//   o_note_active  note currently sounding, 0 otherwise
module piano_tone_gen
    import piano_pkg::*;
#(
    parameter int GAP_CYCLES = 2_000_000,
    parameter int HALF_SHIFT = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [3:0] i_note_in,
    output logic       o_buzzer_out,
    output logic       o_playing,
    output logic [3:0] o_note_active
);

    localparam int GW         = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LOAD_I);

    tone_state_t       r_state;
    logic [3:0]        r_note;
    logic [HALF_W-1:0] r_cnt;
    logic [GW-1:0]     r_gcnt;
    logic              r_buzz;
    logic              r_playing;
    logic [3:0]        r_note_active;

    tone_state_t       w_state_nxt;
    logic [3:0]        w_note_nxt;
    logic [HALF_W-1:0] w_cnt_nxt;
    logic [GW-1:0]     w_gcnt_nxt;
    logic              w_buzz_nxt;
    logic              w_go;
    logic [HALF_W-1:0] w_half;

    // The counter always times the latched note, never the live input.
    note_period_rom #(
        .HALF_SHIFT (HALF_SHIFT)
    ) u_rom (
        .i_note (r_note),
        .o_half (w_half)
    );

    assign w_go = i_en && note_valid(i_note_in);

    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_buzz_nxt  = r_buzz;
        case (r_state)
            ST_IDLE: begin
                w_buzz_nxt = 1'b0;
                w_cnt_nxt  = '0;
                if (w_go) begin
                    w_state_nxt = ST_TONE;
                    w_note_nxt  = i_note_in;
                    w_buzz_nxt  = 1'b1;
                end
            end
            ST_TONE: begin
                if (!w_go) begin
                    w_state_nxt = ST_IDLE;
                    w_buzz_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (i_note_in != r_note) begin
                    w_cnt_nxt = '0;
                    if (GAP_CYCLES == 0) begin
                        w_note_nxt = i_note_in;
                        w_buzz_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_buzz_nxt  = 1'b0;
                        w_gcnt_nxt  = GAP_LOAD;
                    end
                end else if (r_cnt == w_half - 18'd1) begin
                    w_buzz_nxt = ~r_buzz;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 18'd1;
                end
            end
            ST_GAP: begin
                w_buzz_nxt = 1'b0;
                w_cnt_nxt  = '0;
                if (!w_go) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gcnt == '0) begin
                    // Whatever note is present when the gap expires wins.
                    w_state_nxt = ST_TONE;
                    w_note_nxt  = i_note_in;
                    w_buzz_nxt  = 1'b1;
                end else begin
                    w_gcnt_nxt = r_gcnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_buzz_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_note        <= NOTE_REST;
            r_cnt         <= '0;
            r_gcnt        <= '0;
            r_buzz        <= 1'b0;
            r_playing     <= 1'b0;
            r_note_active <= NOTE_REST;
        end else begin
            r_state       <= w_state_nxt;
            r_note        <= w_note_nxt;
            r_cnt         <= w_cnt_nxt;
            r_gcnt        <= w_gcnt_nxt;
            r_buzz        <= w_buzz_nxt;
            r_playing     <= (w_state_nxt == ST_TONE);
            r_note_active <= (w_state_nxt == ST_TONE) ? w_note_nxt : NOTE_REST;
        end
    end

    assign o_buzzer_out  = r_buzz;
    assign o_playing     = r_playing;
    assign o_note_active = r_note_active;

endmodule

// File: tb/tb_piano_tone_gen.sv
// tb/tb_piano_tone_gen.sv - self-checking bench for piano_tone_gen
module tb_piano_tone_gen;

    localparam int SHIFT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] note = 4'd0;

    logic       buz [2];
    logic       ply [2];
    logic [3:0] act [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model per instance: 0 idle, 1 gap, 2 tone.
    int gapv [2] = '{8, 0};
    int m_st [2];
    int m_note [2];
    int m_t [2];
    int m_g [2];

    always #5 clk = ~clk;

    piano_tone_gen #(.GAP_CYCLES(8), .HALF_SHIFT(SHIFT)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_note_in(note),
        .o_buzzer_out(buz[0]), .o_playing(ply[0]), .o_note_active(act[0])
    );

    piano_tone_gen #(.GAP_CYCLES(0), .HALF_SHIFT(SHIFT)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_note_in(note),
        .o_buzzer_out(buz[1]), .o_playing(ply[1]), .o_note_active(act[1])
    );

    function automatic int half_of(input int n);
        int h;
        case (n)
            1: h = 191110;  2: h = 170265;  3: h = 151685;  4: h = 143172;
            5: h = 127551;  6: h = 113636;  7: h = 101239;  8: h = 95555;
            9: h = 85132;  10: h = 75843;  11: h = 71586;  12: h = 63776;
            13: h = 56818; 14: h = 50620;
            default: h = 0;
        endcase
        return h >> SHIFT;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_note[i] = 0; m_t[i] = 0; m_g[i] = 0;
        end
    endtask

    // Advance the model across one clock edge given the inputs present now.
    task automatic model_edge();
        bit go;
        go = en && (note >= 1) && (note <= 14);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_st[i] = 0; m_note[i] = 0; m_t[i] = 0; m_g[i] = 0;
            end else if (m_st[i] == 0) begin
                if (go) begin m_st[i] = 2; m_note[i] = note; m_t[i] = 0; end
            end else if (m_st[i] == 2) begin
                if (!go) m_st[i] = 0;
                else if (note != m_note[i]) begin
                    if (gapv[i] == 0) begin m_note[i] = note; m_t[i] = 0; end
                    else begin m_st[i] = 1; m_g[i] = gapv[i]; end
                end else m_t[i]++;
            end else begin
                if (!go) m_st[i] = 0;
                else begin
                    m_g[i]--;
                    if (m_g[i] == 0) begin m_st[i] = 2; m_note[i] = note; m_t[i] = 0; end
                end
            end
        end
    endtask

    task automatic cmp_all();
        int eb;
        for (int i = 0; i < 2; i++) begin
            eb = (m_st[i] == 2) && (((m_t[i] / half_of(m_note[i])) % 2) == 0);
            chk($sformatf("buzzer[%0d]", i), int'(buz[i]), eb);
            chk($sformatf("playing[%0d]", i), int'(ply[i]), int'(m_st[i] == 2));
            chk($sformatf("note_active[%0d]", i), int'(act[i]), (m_st[i] == 2) ? m_note[i] : 0);
        end
    endtask

    task automatic step(input bit e, input int n);
        @(negedge clk);
        en = e;
        note = 4'(n);
        model_edge();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic run(input bit e, input int n, input int cycles);
        for (int k = 0; k < cycles; k++) step(e, n);
    endtask

    initial begin
        model_reset();
        // Held in reset with a valid note requested.
        run(1, 6, 3);
        chk("reset_buzzer", int'(buz[0]), 0);
        chk("reset_active", int'(act[0]), 0);

        // Start A4: high for 110 clocks, then low for 110.
        rst_n = 1'b1;
        step(1, 6);
        chk("a4_start_high", int'(buz[0]), 1);
        chk("a4_active", int'(act[0]), 6);
        run(1, 6, 109);
        chk("a4_last_high", int'(buz[0]), 1);
        step(1, 6);
        chk("a4_first_low", int'(buz[0]), 0);
        run(1, 6, 110);
        chk("a4_second_high", int'(buz[0]), 1);

        // A4 -> C4: 8-clock gap on dut8, immediate restart on dut0.
        step(1, 1);
        chk("gap_low", int'(buz[0]), 0);
        chk("gap_playing", int'(ply[0]), 0);
        chk("nogap_high", int'(buz[1]), 1);
        chk("nogap_active", int'(act[1]), 1);
        run(1, 1, 7);
        chk("gap_still_low", int'(buz[0]), 0);
        step(1, 1);
        chk("c4_after_gap", int'(buz[0]), 1);
        chk("c4_active", int'(act[0]), 1);
        run(1, 1, 185);
        chk("c4_last_high", int'(buz[0]), 1);
        step(1, 1);
        chk("c4_first_low", int'(buz[0]), 0);

        // Note changes during the gap: the note present at expiry wins.
        step(1, 6);
        run(1, 1, 3);
        run(1, 8, 4);
        chk("gap2_low", int'(buz[0]), 0);
        step(1, 8);
        chk("c5_after_gap", int'(buz[0]), 1);
        chk("c5_active", int'(act[0]), 8);
        run(1, 8, 92);
        step(1, 8);
        chk("c5_first_low", int'(buz[0]), 0);

        // Rest, reserved and mute each silence at once; recovery has no gap.
        step(1, 0);
        chk("rest_silent", int'(ply[0]), 0);
        step(1, 6);
        chk("rest_restart", int'(buz[0]), 1);
        run(1, 6, 20);
        step(1, 15);
        chk("rsvd_silent", int'(act[0]), 0);
        step(1, 6);
        chk("rsvd_restart", int'(buz[0]), 1);
        run(1, 6, 20);
        step(0, 6);
        chk("mute_silent", int'(buz[0]), 0);
        step(1, 6);
        chk("unmute_restart", int'(buz[0]), 1);

        // Asynchronous reset in the middle of a high phase.
        run(1, 6, 50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_buzzer", int'(buz[0]), 0);
        chk("async_playing", int'(ply[0]), 0);
        chk("async_active", int'(act[0]), 0);
        model_reset();
        run(1, 6, 2);
        rst_n = 1'b1;
        step(1, 6);
        chk("post_reset_high", int'(buz[0]), 1);
        run(1, 6, 109);
        step(1, 6);
        chk("post_reset_low", int'(buz[0]), 0);

        // Randomized note/enable sequences, short holds exercise gap interrupts.
        for (int s = 0; s < 40; s++) begin
            bit e;
            int n, hold;
            e = ($urandom_range(0, 7) != 0);
            n = $urandom_range(0, 15);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : $urandom_range(20, 300);
            run(e, n, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
